// File: rtl/led_display_frame_writer_if.sv
// Pixel stream, clear command, frame RAM port A write bus and bank status for the frame writer.
interface led_display_frame_writer_if;
  logic [2:0]  pixel_in;
  logic        pixel_sof_in;
  logic        pixel_valid_in;
  logic        pixel_ready_out;
  logic        clear_req_in;
  logic [2:0]  clear_colour_in;
  logic [3:0]  ram_wen_out;
  logic [31:0] ram_addr_out;
  logic [31:0] ram_wdata_out;
  logic        display_bank_out;
  logic        frame_done_out;
  logic        frame_error_out;

  modport master (
    output pixel_in, pixel_sof_in, pixel_valid_in, clear_req_in, clear_colour_in,
    input  pixel_ready_out, ram_wen_out, ram_addr_out, ram_wdata_out,
    input  display_bank_out, frame_done_out, frame_error_out
  );

  modport slave (
    input  pixel_in, pixel_sof_in, pixel_valid_in, clear_req_in, clear_colour_in,
    output pixel_ready_out, ram_wen_out, ram_addr_out, ram_wdata_out,
    output display_bank_out, frame_done_out, frame_error_out
  );
endinterface

// File: rtl/led_display_frame_writer.sv
// Packs a raster RGB pixel stream into 32-bit words and writes it into the back bank of a
// double-buffered frame RAM, publishing the bank on completion; also supports whole-frame fill.
//
// state | meaning
// IDLE  | waiting for sof pixel or clear request
// PACK  | collecting frame pixels, writing a word every PIXELS_PER_WORD accepts
// CLEAR | writing fill words, one per cycle
// FLUSH | last word on the bus; publish bank next edge
module led_display_frame_writer #(
  parameter int          NUM_ROW_PIXELS  = 32,
  parameter int          NUM_COL_PIXELS  = 64,
  parameter int          PIXELS_PER_WORD = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h0
) (
  input logic                  clk_in,
  input logic                  n_reset_in,
  led_display_frame_writer_if.slave bus
);
  localparam int FRAME_WORDS = NUM_ROW_PIXELS * NUM_COL_PIXELS / PIXELS_PER_WORD;
  localparam int WORD_W      = $clog2(FRAME_WORDS);
  localparam int PIX_W       = $clog2(PIXELS_PER_WORD);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIXELS_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, PACK, CLEAR, FLUSH} state_t;

  state_t            state;
  logic              ready_en;
  logic [PIX_W-1:0]  pix_cnt;
  logic [WORD_W-1:0] word_idx;
  logic [31:0]       word_buf;
  logic [31:0]       packed_word;
  logic [31:0]       fill_word;
  logic [2:0]        clear_colour;
  logic              bank;
  logic [3:0]        wen;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              frame_done;
  logic              frame_error;
  logic              accept;

  // A pending clear in IDLE blocks pixels in the same cycle so clear wins the race.
  assign bus.pixel_ready_out  = ready_en & ~((state == IDLE) & bus.clear_req_in);
  assign accept               = bus.pixel_valid_in & bus.pixel_ready_out;
  assign bus.ram_wen_out      = wen;
  assign bus.ram_addr_out     = addr;
  assign bus.ram_wdata_out    = wdata;
  assign bus.display_bank_out = bank;
  assign bus.frame_done_out   = frame_done;
  assign bus.frame_error_out  = frame_error;

  always_comb begin
    packed_word = word_buf;
    packed_word[{pix_cnt, 2'b00} +: 4] = {1'b0, bus.pixel_in};
    fill_word = {PIXELS_PER_WORD{1'b0, clear_colour}};
  end

  function automatic logic [31:0] word_addr(input logic wbank, input logic [WORD_W-1:0] idx);
    logic [31:0] offset;
    offset = (wbank ? 32'(FRAME_WORDS) : 32'd0) + 32'(idx);
    return BASE_ADDR + (offset << 2);
  endfunction

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state        <= IDLE;
      ready_en     <= 1'b0;
      pix_cnt      <= '0;
      word_idx     <= '0;
      word_buf     <= '0;
      clear_colour <= '0;
      bank         <= 1'b0;
      wen          <= 4'h0;
      addr         <= '0;
      wdata        <= '0;
      frame_done   <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      wen         <= 4'h0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          ready_en <= 1'b1;
          if (bus.clear_req_in) begin
            clear_colour <= bus.clear_colour_in;
            word_idx     <= '0;
            ready_en     <= 1'b0;
            state        <= CLEAR;
          end else if (accept && bus.pixel_sof_in) begin
            word_buf <= 32'({1'b0, bus.pixel_in});
            pix_cnt  <= PIX_W'(1);
            word_idx <= '0;
            state    <= PACK;
          end
        end
        PACK: begin
          if (accept && bus.pixel_sof_in) begin
            frame_error <= 1'b1;
            word_buf    <= 32'({1'b0, bus.pixel_in});
            pix_cnt     <= PIX_W'(1);
            word_idx    <= '0;
          end else if (accept) begin
            word_buf <= packed_word;
            if (pix_cnt == LAST_PIX) begin
              pix_cnt  <= '0;
              wen      <= 4'hF;
              addr     <= word_addr(~bank, word_idx);
              wdata    <= packed_word;
              word_idx <= word_idx + 1'b1;
              if (word_idx == LAST_WORD) begin
                ready_en <= 1'b0;
                state    <= FLUSH;
              end
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        CLEAR: begin
          wen      <= 4'hF;
          addr     <= word_addr(~bank, word_idx);
          wdata    <= fill_word;
          word_idx <= word_idx + 1'b1;
          if (word_idx == LAST_WORD) state <= FLUSH;
        end
        FLUSH: begin
          frame_done <= 1'b1;
          bank       <= ~bank;
          ready_en   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_display_frame_writer.sv
// Randomized bench for led_display_frame_writer: accepted pixels feed a frame-level reference
// model whose expected RAM writes, pulses and bank are compared with what the DUT produces.
module tb_led_display_frame_writer;
  localparam int FRAME_WORDS = 256;
  localparam int FRAME_PIX   = 2048;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  led_display_frame_writer_if bus ();

  led_display_frame_writer #(
    .NUM_ROW_PIXELS (32),
    .NUM_COL_PIXELS (64),
    .PIXELS_PER_WORD(8),
    .BASE_ADDR      (32'h0)
  ) dut (
    .clk_in    (clk),
    .n_reset_in(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observed side
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (bus.ram_wen_out != 4'h0) begin
      check_eq("wen_all_bytes", 32'(bus.ram_wen_out), 32'hF);
      obs_addr.push_back(bus.ram_addr_out);
      obs_data.push_back(bus.ram_wdata_out);
    end
    if (bus.frame_done_out) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.frame_error_out) err_cnt++;
  end

  // Reference model: frame-level view of the accepted pixel stream
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          m_in_frame = 0;
  int          m_len      = 0;
  logic [31:0] m_word     = '0;
  bit          m_bank     = 0;
  int          exp_done   = 0;
  int          exp_err    = 0;
  int          last_acc_cyc = 0;

  function automatic logic [31:0] addr_of(input bit wbank, input int w);
    return 32'(((wbank ? FRAME_WORDS : 0) + w) * 4);
  endfunction

  task automatic model_pixel(input logic [2:0] p, input bit sof);
    if (sof) begin
      if (m_in_frame) exp_err++;
      m_in_frame = 1;
      m_len      = 0;
      m_word     = '0;
    end
    if (m_in_frame) begin
      m_word = m_word | (32'(p) << (4 * (m_len % 8)));
      m_len++;
      if (m_len % 8 == 0) begin
        exp_addr.push_back(addr_of(!m_bank, m_len / 8 - 1));
        exp_data.push_back(m_word);
        m_word = '0;
      end
      if (m_len == FRAME_PIX) begin
        m_in_frame = 0;
        m_bank     = !m_bank;
        exp_done++;
      end
    end
  endtask

  task automatic model_clear(input logic [2:0] c);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d = d | (32'(c) << (4 * k));
    for (int w = 0; w < FRAME_WORDS; w++) begin
      exp_addr.push_back(addr_of(!m_bank, w));
      exp_data.push_back(d);
    end
    m_bank = !m_bank;
    exp_done++;
  endtask

  task automatic model_reset();
    m_in_frame = 0;
    m_bank     = 0;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_eq({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
      check_eq($sformatf("%s_data[%0d]", tag, i), obs_data[i], exp_data[i]);
    end
    check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check_eq({tag, "_bank"}, 32'(bus.display_bank_out), 32'(m_bank));
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic send_seq(input int n, input bit sof_first, input bit rand_valid, input bit rand_pix);
    int i = 0;
    int guard = 0;
    logic v;
    logic [2:0] p;
    logic s;
    while (i < n && guard < n * 4 + 50) begin
      @(negedge clk);
      guard++;
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      p = rand_pix ? 3'($urandom_range(0, 7)) : 3'(i % 8);
      s = sof_first && (i == 0);
      bus.pixel_valid_in = v;
      bus.pixel_in       = p;
      bus.pixel_sof_in   = s;
      #1;
      if (v && bus.pixel_ready_out) begin
        model_pixel(p, s);
        last_acc_cyc = cyc;
        i++;
      end
    end
    check_eq("pixels_accepted", 32'(i), 32'(n));
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.pixel_valid_in = 1'b0;
    bus.pixel_sof_in   = 1'b0;
    bus.clear_req_in   = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    int k = 0;
    while (done_cnt == start && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("done_seen", 32'(done_cnt), 32'(start + 1));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_pattern_frame(input string tag, input logic [31:0] first, input logic [31:0] last);
    if (obs_addr.size() == FRAME_WORDS) begin
      check_eq({tag, "_first_addr"}, obs_addr[0], first);
      check_eq({tag, "_last_addr"}, obs_addr[FRAME_WORDS-1], last);
      for (int i = 0; i < FRAME_WORDS; i++)
        check_eq($sformatf("%s_const_data[%0d]", tag, i), obs_data[i], 32'h76543210);
    end else begin
      check_eq({tag, "_frame_words"}, 32'(obs_addr.size()), 32'(FRAME_WORDS));
    end
  endtask

  initial begin
    int d0;
    int hits;
    bus.pixel_in        = '0;
    bus.pixel_sof_in    = 1'b0;
    bus.pixel_valid_in  = 1'b0;
    bus.clear_req_in    = 1'b0;
    bus.clear_colour_in = '0;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(bus.pixel_ready_out), 32'h0);
    check_eq("rst_wen", 32'(bus.ram_wen_out), 32'h0);
    check_eq("rst_bank", 32'(bus.display_bank_out), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check_eq("idle_ready", 32'(bus.pixel_ready_out), 32'h1);
    check_eq("idle_addr", bus.ram_addr_out, 32'h0);
    check_eq("idle_wdata", bus.ram_wdata_out, 32'h0);
    check_eq("idle_done", 32'(bus.frame_done_out), 32'h0);
    check_eq("idle_err", 32'(bus.frame_error_out), 32'h0);
    check_eq("idle_writes", 32'(obs_addr.size()), 32'h0);

    // 2: two pattern frames, continuous valid
    d0 = done_cnt;
    send_seq(FRAME_PIX, 1, 0, 0);
    go_idle();
    wait_done(d0, 20);
    check_eq("done_latency", 32'(done_cyc), 32'(last_acc_cyc + 2));
    check_pattern_frame("s2a", 32'h400, 32'h7FC);
    compare_writes("s2a");
    d0 = done_cnt;
    send_seq(FRAME_PIX, 1, 0, 0);
    go_idle();
    wait_done(d0, 20);
    check_pattern_frame("s2b", 32'h000, 32'h3FC);
    compare_writes("s2b");

    // 3: stray pixels then a frame with random valid
    send_seq(5, 0, 0, 1);
    go_idle();
    d0 = done_cnt;
    send_seq(FRAME_PIX, 1, 1, 0);
    go_idle();
    wait_done(d0, 20);
    check_pattern_frame("s3", 32'h400, 32'h7FC);
    compare_writes("s3");

    // 4: mid-frame sof
    reset_dut();
    d0 = done_cnt;
    send_seq(100, 1, 0, 0);
    send_seq(FRAME_PIX, 1, 0, 0);
    go_idle();
    wait_done(d0, 20);
    if (obs_addr.size() > 12) begin
      check_eq("s4_w11_addr", obs_addr[11], 32'h42C);
      check_eq("s4_restart_addr", obs_addr[12], 32'h400);
    end
    check_eq("s4_err_pulses", 32'(err_cnt), 32'h1);
    compare_writes("s4");

    // 5: clear with valid held high
    reset_dut();
    d0 = done_cnt;
    hits = 0;
    @(negedge clk);
    bus.clear_req_in    = 1'b1;
    bus.clear_colour_in = 3'b101;
    bus.pixel_valid_in  = 1'b1;
    bus.pixel_sof_in    = 1'b0;
    bus.pixel_in        = 3'($urandom_range(0, 7));
    #1;
    check_eq("clear_ready_comb", 32'(bus.pixel_ready_out), 32'h0);
    model_clear(3'b101);
    for (int k = 0; k < 400 && done_cnt == d0; k++) begin
      @(negedge clk);
      bus.clear_req_in = 1'b0;
      bus.pixel_in     = 3'($urandom_range(0, 7));
      #1;
      if (done_cnt == d0 && bus.pixel_ready_out) hits++;
    end
    check_eq("done_seen", 32'(done_cnt), 32'(d0 + 1));
    check_eq("clear_ready_hits", 32'(hits), 32'h0);
    if (obs_addr.size() == FRAME_WORDS) begin
      check_eq("s5_first_addr", obs_addr[0], 32'h400);
      check_eq("s5_last_addr", obs_addr[FRAME_WORDS-1], 32'h7FC);
      check_eq("s5_data0", obs_data[0], 32'h55555555);
    end
    go_idle();
    compare_writes("s5");

    // 6: reset mid-frame, then a random frame
    send_seq(1000, 1, 0, 1);
    go_idle();
    repeat (2) @(negedge clk);
    check_eq("s6_bank_before", 32'(bus.display_bank_out), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_wen", 32'(bus.ram_wen_out), 32'h0);
    check_eq("s6_rst_addr", bus.ram_addr_out, 32'h0);
    check_eq("s6_rst_wdata", bus.ram_wdata_out, 32'h0);
    check_eq("s6_rst_bank", 32'(bus.display_bank_out), 32'h0);
    check_eq("s6_rst_ready", 32'(bus.pixel_ready_out), 32'h0);
    model_reset();
    compare_writes("s6_pre");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    send_seq(FRAME_PIX, 1, 1, 1);
    go_idle();
    wait_done(d0, 20);
    if (obs_addr.size() > 0) check_eq("s6_first_addr", obs_addr[0], 32'h400);
    compare_writes("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/led_display_frame_writer.md
Name: led_display_frame_writer

Overview:
- Write-side counterpart of led_display_ram_control. Accepts a raster-order 3-bit RGB pixel stream with a valid/ready handshake.
- Packs pixels into 32-bit words and writes them through frame_ram port A (clka/wea/addra/dina).
- Frame storage is double-buffered: the writer fills the back bank, then publishes it by toggling display_bank_out, which the read controller uses as its bank select.
- Also provides a whole-frame clear/fill command.

Parameters:
- NUM_ROW_PIXELS, 32, display rows.
- NUM_COL_PIXELS, 64, display columns.
- PIXELS_PER_WORD, 8, pixels packed per 32-bit RAM word. Each pixel uses a 4-bit nibble.
- BASE_ADDR, 32'h0, byte base address of bank 0.
- Derived: FRAME_WORDS = NUM_ROW_PIXELS*NUM_COL_PIXELS/PIXELS_PER_WORD (256 at defaults).

Ports:
- clk_in  in  1  system clock.
- n_reset_in  in  1  asynchronous reset, active-low.
- pixel_in  in  3  {blue, green, red}.
- pixel_sof_in  in  1  marks the first pixel of a frame.
- pixel_valid_in  in  1  pixel valid.
- pixel_ready_out  out  1  pixel ready.
- clear_req_in  in  1  request to fill the back bank with one colour.
- clear_colour_in  in  3  fill colour, sampled when the clear is accepted.
- ram_wen_out  out  4  byte write enables; 4'hF or 4'h0.
- ram_addr_out  out  32  byte address.
- ram_wdata_out  out  32  write data.
- display_bank_out  out  1  bank currently owned by the reader.
- frame_done_out  out  1  one-cycle pulse when a bank is published.
- frame_error_out  out  1  one-cycle pulse on a mid-frame sof.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0; display_bank_out = 0, so the write bank is 1.
  - State IDLE; all counters 0.
  - pixel_ready_out = 0 while n_reset_in is low.
  - Reset mid-frame or mid-clear abandons the operation. There are no further writes and the bank does not toggle.
- Accept: a pixel is accepted when pixel_valid_in && pixel_ready_out on a clk_in edge.
- pixel_ready_out = 1 in IDLE and PACK. It is 0 in CLEAR, and 0 in IDLE while clear_req_in = 1 (combinational).
- Word packing:
  - Pixel k of a word occupies bits [4k+2:4k]; bit 4k+3 = 0.
  - Pixel 0 is the LSB nibble. Pixels are in raster order: row 0 columns 0..63, then row 1, and so on.
- Address: ram_addr_out = BASE_ADDR + ((wbank*FRAME_WORDS + word_idx) << 2), where wbank = ~display_bank_out. At defaults, bank 1 spans 0x400..0x7FC.
- Write timing:
  - A word is written one cycle after its 8th pixel is accepted: ram_wen_out = 4'hF for exactly one cycle, with address and data valid in that cycle.
  - Otherwise ram_wen_out = 4'h0.
  - Throughput is one pixel per cycle with no stall; packing continues during the write cycle.
- State IDLE:
  - Accepted pixel with sof: load it as pixel 0 of word 0, go to PACK.
  - Accepted pixel without sof: drop it silently, no write.
  - clear_req_in = 1: latch clear_colour_in, go to CLEAR. Clear has priority over pixels.
- State PACK:
  - Each accept increments the pixel count. Word boundaries issue writes as above.
  - Accepted pixel with sof: pulse frame_error_out next cycle and discard the partial word. Restart at word 0 of the same write bank with this pixel as pixel 0. Words already written are not rolled back.
  - clear_req_in is ignored in PACK.
  - Last pixel (index FRAME_WORDS*8-1) accepted at cycle N:
    - word FRAME_WORDS-1 is written at N+1;
    - at N+2, frame_done_out pulses and display_bank_out toggles;
    - the block returns to IDLE at N+2.
- State CLEAR:
  - Writes FRAME_WORDS consecutive words, one per cycle, starting the cycle after entry, to the write bank.
  - Data = colour replicated into all 8 nibbles (nibble = {1'b0, colour}).
  - The cycle after the last write: frame_done_out pulses, display_bank_out toggles, return to IDLE.
- display_bank_out changes only at frame_done_out.

Test Plan:
1. Reset, then release; idle 10 cycles -> all outputs 0, display_bank_out = 0, pixel_ready_out = 1, no writes.
2. Full frame with pixel i = i mod 8, sof on i = 0, valid continuous:
   - 256 writes, each data 0x76543210;
   - first at address 0x400, last at 0x7FC, addresses stepping by 4;
   - frame_done_out one pulse, two cycles after the last accept; display_bank_out -> 1.
   - Second identical frame -> writes 0x000..0x3FC, bank -> 0.
3. Five pixels without sof in IDLE, then a frame with valid toggling randomly -> the five pixels produce no writes; the frame's writes and data are identical to scenario 2.
4. sof, 99 more pixels, then sof again:
   - 12 writes (0x400..0x42C);
   - frame_error_out pulses once;
   - the 4-pixel partial is discarded;
   - the next write is again at 0x400;
   - the frame then completes normally with one frame_done_out.
5. clear_req_in with clear_colour_in = 3'b101 in IDLE, with valid held high:
   - pixel_ready_out = 0 for the whole clear; no pixels accepted;
   - 256 writes of 0x55555555 at 0x400..0x7FC;
   - then frame_done_out pulse and bank toggle.
6. n_reset_in asserted after 1000 pixels -> outputs 0 asynchronously, display_bank_out = 0; after release, a new frame writes from 0x400.
